fighter_player: RTL and testbench



---
 rtl/fighter_pkg.sv | 48 ++++
 rtl/fighter_hit_resolver.sv | 59 +++++
 rtl/fighter_player.sv | 156 +++++++++++++++
 tb/tb_fighter_player.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared action encodings and arithmetic helpers for the fighter blocks.
package fighter_pkg;

    localparam int ACT_W = 6;
    localparam int DMG_W = 4;

    localparam logic [ACT_W-1:0] ACT_MOVE_RIGHT = 6'b100000;
    localparam logic [ACT_W-1:0] ACT_MOVE_LEFT  = 6'b010000;
    localparam logic [ACT_W-1:0] ACT_WAIT       = 6'b001000;
    localparam logic [ACT_W-1:0] ACT_JUMP       = 6'b000100;
    localparam logic [ACT_W-1:0] ACT_KICK       = 6'b000010;
    localparam logic [ACT_W-1:0] ACT_PUNCH      = 6'b000001;
    localparam logic [ACT_W-1:0] ACT_IDLE       = 6'b000000;

    // True when exactly one action bit is set.
    function automatic logic act_is_onehot(input logic [ACT_W-1:0] a);
        return (a != 6'b000000) && ((a & (a - 6'b000001)) == 6'b000000);
    endfunction

    // Zero or multi-hot actions collapse to IDLE.
    function automatic logic [ACT_W-1:0] act_clean(input logic [ACT_W-1:0] a);
        if (act_is_onehot(a)) begin
            return a;
        end else begin
            return ACT_IDLE;
        end
    endfunction

    // a - b, clamped at zero.
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        if (b >= a) begin
            return 32'd0;
        end else begin
            return a - b;
        end
    endfunction

    // a + b, clamped at ceil.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned ceil);
        if ((a + b) >= ceil) begin
            return ceil;
        end else begin
            return a + b;
        end
    endfunction

endpackage

// File: rtl/fighter_hit_resolver.sv
// Combinational resolution of incoming attacks into damage and knockback.
module fighter_hit_resolver
    import fighter_pkg::*;
#(
    parameter int PUNCH_DMG = 2,
    parameter int KICK_DMG  = 1,
    parameter int GAP_W     = 3
) (
    input  logic [ACT_W-1:0] own_act,
    input  logic [ACT_W-1:0] opp_act,
    input  logic [GAP_W-1:0] gap,
    input  logic             own_air,
    input  logic             opp_air,
    output logic [DMG_W-1:0] dmg,
    output logic             knockback
);

    // Attacks only connect when both fighters are on the ground.
    always_comb begin
        dmg       = {DMG_W{1'b0}};
        knockback = 1'b0;
        if (!own_air && !opp_air) begin
            case (opp_act)
                ACT_PUNCH: begin
                    if (gap == {GAP_W{1'b0}}) begin
                        knockback = 1'b1;
                        if (own_act == ACT_PUNCH) begin
                            dmg = {DMG_W{1'b0}};
                        end else begin
                            dmg = DMG_W'(PUNCH_DMG);
                        end
                    end else begin
                        knockback = 1'b0;
                    end
                end
                ACT_KICK: begin
                    if (gap <= GAP_W'(1)) begin
                        if ((own_act == ACT_PUNCH) && (gap == {GAP_W{1'b0}})) begin
                            knockback = 1'b0;   // parry
                        end else if (own_act == ACT_KICK) begin
                            knockback = 1'b1;   // clash
                        end else begin
                            dmg       = DMG_W'(KICK_DMG);
                            knockback = 1'b1;
                        end
                    end else begin
                        knockback = 1'b0;
                    end
                end
                default: begin
                    knockback = 1'b0;
                end
            endcase
        end else begin
            knockback = 1'b0;
        end
    end

endmodule

// File: rtl/fighter_player.sv
// One fighter: movement, jump timer, regeneration, hit handling and sticky KO.
module fighter_player
    import fighter_pkg::*;
#(
    parameter int SIDE        = 1,
    parameter int POS_MAX     = 2,
    parameter int START_POS   = 0,
    parameter int HEALTH_MAX  = 3,
    parameter int PUNCH_DMG   = 2,
    parameter int KICK_DMG    = 1,
    parameter int REGEN_WAIT  = 2,
    parameter int JUMP_CYCLES = 1,
    localparam int POS_W      = $clog2(POS_MAX + 1),
    localparam int HP_W       = $clog2(HEALTH_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACT_W-1:0] own_action,
    input  logic [ACT_W-1:0] opp_action,
    input  logic [POS_W-1:0] opp_pos,
    input  logic             opp_airborne,
    output logic [POS_W-1:0] pos,
    output logic [HP_W-1:0]  health,
    output logic             airborne,
    output logic             ko,
    output logic             hit_taken
);

    localparam int GAP_W = POS_W + 1;
    localparam int JC_W  = $clog2(JUMP_CYCLES + 1);
    localparam int WC_W  = $clog2(REGEN_WAIT + 1);
    localparam logic [ACT_W-1:0] ACT_FWD  = (SIDE == 0) ? ACT_MOVE_RIGHT : ACT_MOVE_LEFT;
    localparam logic [ACT_W-1:0] ACT_BACK = (SIDE == 0) ? ACT_MOVE_LEFT  : ACT_MOVE_RIGHT;

    logic [POS_W-1:0] pos_r, pos_n_s;
    logic [HP_W-1:0]  health_r, health_n_s;
    logic             airborne_r, airborne_n_s;
    logic             ko_r, ko_n_s;
    logic             hit_r, hit_n_s;
    logic [WC_W-1:0]  wait_cnt_r, wait_cnt_n_s;
    logic [JC_W-1:0]  jump_cnt_r, jump_cnt_n_s;

    logic [ACT_W-1:0] own_s, opp_s;
    logic [GAP_W-1:0] gap_s;
    logic [DMG_W-1:0] dmg_s;
    logic             knockback_s;

    assign own_s = act_clean(own_action);
    assign opp_s = act_clean(opp_action);
    assign gap_s = GAP_W'(2 * POS_MAX) - {1'b0, pos_r} - {1'b0, opp_pos};

    fighter_hit_resolver #(
        .PUNCH_DMG (PUNCH_DMG),
        .KICK_DMG  (KICK_DMG),
        .GAP_W     (GAP_W)
    ) u_hit (
        .own_act   (own_s),
        .opp_act   (opp_s),
        .gap       (gap_s),
        .own_air   (airborne_r),
        .opp_air   (opp_airborne),
        .dmg       (dmg_s),
        .knockback (knockback_s)
    );

    // Next-state computation; everything holds once knocked out.
    always_comb begin
        pos_n_s      = pos_r;
        health_n_s   = health_r;
        airborne_n_s = airborne_r;
        ko_n_s       = ko_r;
        hit_n_s      = 1'b0;
        wait_cnt_n_s = wait_cnt_r;
        jump_cnt_n_s = jump_cnt_r;
        if (!ko_r) begin
            // Knockback beats any own move; moves need feet on the ground.
            if (knockback_s) begin
                if (pos_r == {POS_W{1'b0}}) begin
                    pos_n_s = pos_r;
                end else begin
                    pos_n_s = pos_r - POS_W'(1);
                end
            end else if (!airborne_r && (own_s == ACT_FWD) &&
                         (pos_r < POS_W'(POS_MAX)) && (gap_s != {GAP_W{1'b0}})) begin
                pos_n_s = pos_r + POS_W'(1);
            end else if (!airborne_r && (own_s == ACT_BACK) && (pos_r != {POS_W{1'b0}})) begin
                pos_n_s = pos_r - POS_W'(1);
            end else begin
                pos_n_s = pos_r;
            end

            // Jump timer counts down the remaining airborne cycles.
            if (airborne_r) begin
                if (jump_cnt_r <= JC_W'(1)) begin
                    airborne_n_s = 1'b0;
                    jump_cnt_n_s = {JC_W{1'b0}};
                end else begin
                    jump_cnt_n_s = jump_cnt_r - JC_W'(1);
                end
            end else if (own_s == ACT_JUMP) begin
                airborne_n_s = 1'b1;
                jump_cnt_n_s = JC_W'(JUMP_CYCLES);
            end else begin
                airborne_n_s = 1'b0;
                jump_cnt_n_s = {JC_W{1'b0}};
            end

            // Damage takes precedence over regeneration.
            if (dmg_s != {DMG_W{1'b0}}) begin
                health_n_s   = HP_W'(sat_sub(32'(health_r), 32'(dmg_s)));
                hit_n_s      = 1'b1;
                wait_cnt_n_s = {WC_W{1'b0}};
                ko_n_s       = (health_n_s == {HP_W{1'b0}});
            end else if (own_s == ACT_WAIT) begin
                if (wait_cnt_r == WC_W'(REGEN_WAIT - 1)) begin
                    health_n_s   = HP_W'(sat_add(32'(health_r), 32'd1, 32'(HEALTH_MAX)));
                    wait_cnt_n_s = {WC_W{1'b0}};
                end else begin
                    wait_cnt_n_s = wait_cnt_r + WC_W'(1);
                end
            end else begin
                wait_cnt_n_s = {WC_W{1'b0}};
            end
        end else begin
            hit_n_s = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r      <= POS_W'(START_POS);
            health_r   <= HP_W'(HEALTH_MAX);
            airborne_r <= 1'b0;
            ko_r       <= 1'b0;
            hit_r      <= 1'b0;
            wait_cnt_r <= {WC_W{1'b0}};
            jump_cnt_r <= {JC_W{1'b0}};
        end else begin
            pos_r      <= pos_n_s;
            health_r   <= health_n_s;
            airborne_r <= airborne_n_s;
            ko_r       <= ko_n_s;
            hit_r      <= hit_n_s;
            wait_cnt_r <= wait_cnt_n_s;
            jump_cnt_r <= jump_cnt_n_s;
        end
    end

    assign pos       = pos_r;
    assign health    = health_r;
    assign airborne  = airborne_r;
    assign ko        = ko_r;
    assign hit_taken = hit_r;

endmodule

// File: tb/tb_fighter_player.sv
// Bench for fighter_player (left side, 3-cycle jump): directed table, hand
// sequences for jump/KO/async reset, then random traffic against a model.
module tb_fighter_player;

    localparam logic [5:0] MR = 6'b100000;
    localparam logic [5:0] ML = 6'b010000;
    localparam logic [5:0] WT = 6'b001000;
    localparam logic [5:0] JP = 6'b000100;
    localparam logic [5:0] KK = 6'b000010;
    localparam logic [5:0] PP = 6'b000001;
    localparam logic [5:0] NO = 6'b000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] own_action = 6'd0;
    logic [5:0] opp_action = 6'd0;
    logic [1:0] opp_pos = 2'd0;
    logic       opp_airborne = 1'b0;
    logic [1:0] pos;
    logic [1:0] health;
    logic       airborne, ko, hit_taken;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [5:0] own;
        logic [5:0] opp;
        int opos;
        int epos;
        int ehp;
        int eair;
        int eko;
        int ehit;
    } vec_t;
    vec_t tbl[$];

    // Behavioural model state
    int m_pos, m_hp, m_air_left, m_ko, m_hit, m_wait;

    fighter_player #(
        .SIDE(0), .POS_MAX(2), .START_POS(0), .HEALTH_MAX(3),
        .PUNCH_DMG(2), .KICK_DMG(1), .REGEN_WAIT(2), .JUMP_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .own_action(own_action), .opp_action(opp_action),
        .opp_pos(opp_pos), .opp_airborne(opp_airborne), .pos(pos), .health(health),
        .airborne(airborne), .ko(ko), .hit_taken(hit_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input int p, input int h, input int a,
                           input int k, input int t);
        chk($sformatf("%s.pos", tag), int'(pos), p);
        chk($sformatf("%s.health", tag), int'(health), h);
        chk($sformatf("%s.airborne", tag), int'(airborne), a);
        chk($sformatf("%s.ko", tag), int'(ko), k);
        chk($sformatf("%s.hit_taken", tag), int'(hit_taken), t);
    endtask

    // Called at a negedge: set inputs, let one posedge pass, return at next negedge.
    task automatic drive(input logic [5:0] own, input logic [5:0] opp, input int op,
                         input bit oa);
        own_action = own;
        opp_action = opp;
        opp_pos = 2'(op);
        opp_airborne = oa;
        @(negedge clk);
    endtask

    task automatic add(input logic [5:0] own, input logic [5:0] opp, input int op,
                       input int p, input int h, input int k, input int t);
        vec_t v;
        v.own = own; v.opp = opp; v.opos = op;
        v.epos = p; v.ehp = h; v.eair = 0; v.eko = k; v.ehit = t;
        tbl.push_back(v);
    endtask

    function automatic logic [5:0] clean(input logic [5:0] a);
        return ($countones(a) == 1) ? a : 6'd0;
    endfunction

    function automatic void model_reset();
        m_pos = 0; m_hp = 3; m_air_left = 0; m_ko = 0; m_hit = 0; m_wait = 0;
    endfunction

    // One clock of the game rules, in plain integer arithmetic.
    function automatic void model_step(input logic [5:0] own_raw, input logic [5:0] opp_raw,
                                       input int op, input bit oa);
        logic [5:0] own, opp;
        int gap, dmg;
        bit kb, in_air;
        own = clean(own_raw);
        opp = clean(opp_raw);
        m_hit = 0;
        if (m_ko != 0) return;
        in_air = (m_air_left > 0);
        gap = 4 - m_pos - op;
        dmg = 0; kb = 0;
        if (!in_air && !oa) begin
            if (opp == PP && gap == 0) begin
                kb = 1; dmg = (own == PP) ? 0 : 2;
            end else if (opp == KK && gap <= 1) begin
                if (own == PP && gap == 0) kb = 0;
                else if (own == KK) kb = 1;
                else begin kb = 1; dmg = 1; end
            end
        end
        if (kb) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
        else if (!in_air && own == MR && m_pos < 2 && gap > 0) m_pos++;
        else if (!in_air && own == ML && m_pos > 0) m_pos--;
        if (in_air) m_air_left--;
        else if (own == JP) m_air_left = 3;
        if (dmg > 0) begin
            m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
            m_hit = 1; m_wait = 0;
            if (m_hp == 0) m_ko = 1;
        end else if (own == WT) begin
            m_wait++;
            if (m_wait == 2) begin
                m_hp = (m_hp < 3) ? m_hp + 1 : 3;
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
        end
    endfunction

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_all(tag, 0, 3, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] ro, rp;
        int rop, ko_run;
        bit roa;

        //  own   opp         opos  pos hp ko hit
        add(MR, NO,          0,    1, 3, 0, 0);
        add(MR, NO,          0,    2, 3, 0, 0);
        add(MR, NO,          0,    2, 3, 0, 0);   // already at POS_MAX
        add(NO, PP,          2,    1, 1, 0, 1);   // punch lands at gap 0
        add(6'b100001, NO,   2,    1, 1, 0, 0);   // multi-hot own -> idle
        add(WT, NO,          0,    1, 1, 0, 0);
        add(WT, NO,          0,    1, 2, 0, 0);
        add(WT, NO,          0,    1, 2, 0, 0);
        add(WT, NO,          0,    1, 3, 0, 0);
        add(WT, NO,          0,    1, 3, 0, 0);
        add(WT, NO,          0,    1, 3, 0, 0);   // regen saturates
        add(MR, NO,          2,    2, 3, 0, 0);   // gap 1 allows forward
        add(PP, PP,          2,    1, 3, 0, 0);   // punch vs punch: knockback only
        add(KK, KK,          2,    0, 3, 0, 0);   // kick clash at gap 1
        add(ML, NO,          0,    0, 3, 0, 0);   // back at wall
        add(MR, NO,          0,    1, 3, 0, 0);
        add(MR, NO,          0,    2, 3, 0, 0);
        add(PP, KK,          2,    2, 3, 0, 0);   // parry at gap 0
        add(NO, 6'b000011,   2,    2, 3, 0, 0);   // multi-hot opp -> idle
        add(NO, KK,          2,    1, 2, 0, 1);
        add(NO, KK,          2,    0, 1, 0, 1);   // kick at gap 1
        add(MR, KK,          1,    1, 1, 0, 0);   // out of kick range
        add(WT, NO,          0,    1, 1, 0, 0);
        add(KK, NO,          0,    1, 1, 0, 0);   // breaks wait streak
        add(WT, NO,          0,    1, 1, 0, 0);
        add(WT, KK,          2,    0, 0, 1, 1);   // damage beats regen, KO
        add(MR, PP,          2,    0, 0, 1, 0);   // frozen
        add(JP, NO,          0,    0, 0, 1, 0);   // frozen

        repeat (2) @(negedge clk);
        chk_all("reset", 0, 3, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].own, tbl[i].opp, tbl[i].opos, 1'b0);
            chk_all($sformatf("vec%0d", i), tbl[i].epos, tbl[i].ehp, tbl[i].eair,
                    tbl[i].eko, tbl[i].ehit);
        end

        // Asynchronous reset away from any clock edge clears KO
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 3, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Jump dodges three punches, fourth lands
        drive(MR, NO, 0, 1'b0);
        drive(MR, NO, 0, 1'b0);
        drive(JP, NO, 2, 1'b0);
        chk_all("jump0", 2, 3, 1, 0, 0);
        drive(NO, PP, 2, 1'b0);
        chk_all("jump1", 2, 3, 1, 0, 0);
        drive(JP, PP, 2, 1'b0);
        chk_all("jump2", 2, 3, 1, 0, 0);
        drive(NO, PP, 2, 1'b0);
        chk_all("jump3", 2, 3, 0, 0, 0);
        drive(NO, PP, 2, 1'b0);
        chk_all("jump4", 1, 1, 0, 0, 1);
        // Jump accepted while being kicked does not dodge
        drive(JP, KK, 2, 1'b0);
        chk_all("jump_ko", 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            drive(6'(1 << (i % 6)), PP, 2, 1'b0);
            chk_all($sformatf("frozen%0d", i), 0, 0, 1, 1, 0);
        end
        do_reset("rst_after_ko");

        // Random traffic against the model
        ko_run = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 59) == 0 || ko_run > 4) begin
                do_reset($sformatf("rrst%0d", c));
                ko_run = 0;
            end else begin
                rop = int'($urandom_range(0, 7));
                ro = (rop < 6) ? 6'(1 << rop) : ((rop == 6) ? 6'd0 : 6'($urandom));
                rop = int'($urandom_range(0, 7));
                rp = (rop < 6) ? 6'(1 << rop) : ((rop == 6) ? 6'd0 : 6'($urandom));
                if ($urandom_range(0, 2) == 0) rp = ($urandom_range(0, 1) == 0) ? PP : KK;
                rop = int'($urandom_range(0, 2));
                roa = ($urandom_range(0, 3) == 0);
                drive(ro, rp, rop, roa);
                model_step(ro, rp, rop, roa);
                chk_all($sformatf("rnd%0d", c), m_pos, m_hp, (m_air_left > 0) ? 1 : 0,
                        m_ko, m_hit);
                if (m_ko != 0) ko_run++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
